// File: rtl/gates_pkg.sv
// Shared constants for the gates library.
// Default operand width and reset value of result registers.
package gates_pkg;

   localparam int GATES_DEFAULT_WIDTH = 1;

   // Every result bit resets to this value.
   localparam logic GATES_RST_BIT = 1'b0;

   function automatic logic [63:0] gates_rst_vec();
      return {64{GATES_RST_BIT}};
   endfunction

endpackage

// File: rtl/inv_gate_cell.sv
// Combinational NOT/NAND/NOR cell.
// Pure dataflow, bitwise, no state.
module inv_gate_cell
   import gates_pkg::*;
#(
   parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] not_o,
   output logic [WIDTH-1:0] nand_o,
   output logic [WIDTH-1:0] nor_o
);

   assign not_o  = ~a;
   assign nand_o = ~(a & b);
   assign nor_o  = ~(a | b);

endmodule

// File: rtl/inv_gate_unit.sv
// Registered inverting-gate unit.
// One flop stage over inv_gate_cell with a valid flag.
module inv_gate_unit
   import gates_pkg::*;
#(
   parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] not_o,
   output logic [WIDTH-1:0] nand_o,
   output logic [WIDTH-1:0] nor_o
);

   localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{GATES_RST_BIT}};

   logic [WIDTH-1:0] not_c;
   logic [WIDTH-1:0] nand_c;
   logic [WIDTH-1:0] nor_c;

   inv_gate_cell #(
      .WIDTH(WIDTH)
   ) u_cell (
      .a     (a),
      .b     (b),
      .not_o (not_c),
      .nand_o(nand_c),
      .nor_o (nor_c)
   );

   // Results hold on idle cycles; only the valid flag drops.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         not_o     <= RST_VEC;
         nand_o    <= RST_VEC;
         nor_o     <= RST_VEC;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         not_o     <= not_c;
         nand_o    <= nand_c;
         nor_o     <= nor_c;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inv_gate_unit.sv
// Testbench for inv_gate_unit: WIDTH=1 and WIDTH=8 instances.
// Scoreboard queue of expected results plus directed literal checks.
module tb_inv_gate_unit;

   typedef struct {
      logic       v;
      logic [7:0] n;
      logic [7:0] nd;
      logic [7:0] nr;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] a8;
   logic [7:0] b8;

   logic       v1;
   logic [0:0] not1;
   logic [0:0] nand1;
   logic [0:0] nor1;

   logic       v8;
   logic [7:0] not8;
   logic [7:0] nand8;
   logic [7:0] nor8;

   int checks;
   int failures;

   exp_t sb_q[$];
   exp_t m;

   inv_gate_unit #(.WIDTH(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a8[0:0]),
      .b        (b8[0:0]),
      .out_valid(v1),
      .not_o    (not1),
      .nand_o   (nand1),
      .nor_o    (nor1)
   );

   inv_gate_unit #(.WIDTH(8)) dut8 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a8),
      .b        (b8),
      .out_valid(v8),
      .not_o    (not8),
      .nand_o   (nand8),
      .nor_o    (nor8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, push the model's next state, compare after the edge.
   task automatic step(input string tag,
                       input logic r,
                       input logic iv,
                       input logic [7:0] av,
                       input logic [7:0] bv);
      exp_t e;
      rst      = r;
      in_valid = iv;
      a8       = av;
      b8       = bv;
      if (r) begin
         m.v  = 1'b0;
         m.n  = 8'h00;
         m.nd = 8'h00;
         m.nr = 8'h00;
      end else if (iv) begin
         m.v = 1'b1;
         for (int i = 0; i < 8; i++) begin
            m.n[i]  = (av[i] == 1'b0);
            m.nd[i] = !(av[i] == 1'b1 && bv[i] == 1'b1);
            m.nr[i] = (av[i] == 1'b0 && bv[i] == 1'b0);
         end
      end else begin
         m.v = 1'b0;
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s_sb observed=empty expected=entry", tag);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_v8"}, {7'd0, v8}, {7'd0, e.v});
         chk({tag, "_not8"}, not8, e.n);
         chk({tag, "_nand8"}, nand8, e.nd);
         chk({tag, "_nor8"}, nor8, e.nr);
         chk({tag, "_v1"}, {7'd0, v1}, {7'd0, e.v});
         chk({tag, "_not1"}, {7'd0, not1}, {7'd0, e.n[0]});
         chk({tag, "_nand1"}, {7'd0, nand1}, {7'd0, e.nd[0]});
         chk({tag, "_nor1"}, {7'd0, nor1}, {7'd0, e.nr[0]});
      end
   endtask

   task automatic lit1(input string tag,
                       input logic ev,
                       input logic en,
                       input logic end_,
                       input logic enr);
      chk({tag, "_lv"}, {7'd0, v1}, {7'd0, ev});
      chk({tag, "_lnot"}, {7'd0, not1}, {7'd0, en});
      chk({tag, "_lnand"}, {7'd0, nand1}, {7'd0, end_});
      chk({tag, "_lnor"}, {7'd0, nor1}, {7'd0, enr});
   endtask

   initial begin
      logic       r_r;
      logic       r_v;
      logic [7:0] r_a;
      logic [7:0] r_b;
      checks   = 0;
      failures = 0;
      m.v  = 1'b0;
      m.n  = 8'h00;
      m.nd = 8'h00;
      m.nr = 8'h00;

      step("rst0", 1'b1, 1'b1, 8'hFF, 8'hFF);
      lit1("rst0", 1'b0, 1'b0, 1'b0, 1'b0);
      step("rst1", 1'b1, 1'b1, 8'hFF, 8'hFF);
      lit1("rst1", 1'b0, 1'b0, 1'b0, 1'b0);

      step("tt00", 1'b0, 1'b1, 8'h00, 8'h00);
      lit1("tt00", 1'b1, 1'b1, 1'b1, 1'b1);
      step("tt10", 1'b0, 1'b1, 8'h01, 8'h00);
      lit1("tt10", 1'b1, 1'b0, 1'b1, 1'b0);
      step("tt11", 1'b0, 1'b1, 8'h01, 8'h01);
      lit1("tt11", 1'b1, 1'b0, 1'b0, 1'b0);
      step("tt01", 1'b0, 1'b1, 8'h00, 8'h01);
      lit1("tt01", 1'b1, 1'b1, 1'b1, 1'b0);

      step("hcap", 1'b0, 1'b1, 8'h01, 8'h00);
      lit1("hcap", 1'b1, 1'b0, 1'b1, 1'b0);
      step("hold0", 1'b0, 1'b0, 8'h00, 8'h01);
      lit1("hold0", 1'b0, 1'b0, 1'b1, 1'b0);
      step("hold1", 1'b0, 1'b0, 8'h01, 8'h01);
      lit1("hold1", 1'b0, 1'b0, 1'b1, 1'b0);
      step("hold2", 1'b0, 1'b0, 8'h00, 8'h00);
      lit1("hold2", 1'b0, 1'b0, 1'b1, 1'b0);

      step("vec", 1'b0, 1'b1, 8'hF0, 8'hCC);
      chk("vec_lnot", not8, 8'h0F);
      chk("vec_lnand", nand8, 8'h3F);
      chk("vec_lnor", nor8, 8'h03);

      step("ms0", 1'b0, 1'b1, 8'h5A, 8'h3C);
      step("ms1", 1'b0, 1'b1, 8'hA5, 8'h0F);
      step("msr", 1'b1, 1'b1, 8'h12, 8'h34);
      chk("msr_lv", {7'd0, v8}, 8'h00);
      chk("msr_lnot", not8, 8'h00);
      chk("msr_lnand", nand8, 8'h00);
      chk("msr_lnor", nor8, 8'h00);
      step("msc", 1'b0, 1'b1, 8'h81, 8'h18);
      chk("msc_lv", {7'd0, v8}, 8'h01);
      chk("msc_lnot", not8, 8'h7E);
      chk("msc_lnand", nand8, 8'hFF);
      chk("msc_lnor", nor8, 8'h66);

      for (int i = 0; i < 1000; i++) begin
         r_r = ($urandom_range(0, 49) == 0);
         r_v = $urandom_range(0, 3) != 0;
         r_a = 8'($urandom);
         r_b = 8'($urandom);
         step("rnd", r_r, r_v, r_a, r_b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
